// File: rtl/led_pkg.sv
// Shared definitions for the LED breathing sequencer and the PWM generator.
package led_pkg;

  // Default duty width and peak, shared with the PWM generator.
  localparam int DUTY_W_DEF   = 8;
  localparam int DUTY_MAX_DEF = 255;

  // Breathing profile phases.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    UP     = 3'd1,
    HOLD_H = 3'd2,
    DOWN   = 3'd3,
    HOLD_L = 3'd4
  } state_t;

endpackage

// File: rtl/led_breath_ctrl_if.sv
// Duty-cycle handshake between the breathing sequencer and the PWM generator.
//
// Handshake: a transfer happens on a rising clk edge where duty_valid and
// duty_ready are both 1. While duty_valid is 1, duty holds steady and
// duty_valid stays high until that transfer. duty_ready may be high while
// duty_valid is low; nothing happens then. The only way duty_valid drops
// without a transfer is an asynchronous reset.
interface led_breath_ctrl_if
  import led_pkg::*;
#(
  parameter int DUTY_W = DUTY_W_DEF
);
  logic [DUTY_W-1:0] duty;
  logic              duty_valid;
  logic              duty_ready;

  modport master (output duty, output duty_valid, input duty_ready);
  modport slave  (input duty, input duty_valid, output duty_ready);
endinterface

// File: rtl/led_sat_step.sv
// Saturating step of a duty level by STEP, bounded to 0..DUTY_MAX.
module led_sat_step #(
  parameter int DUTY_W   = 8,
  parameter int DUTY_MAX = 255,
  parameter int STEP     = 1
) (
  input  logic [DUTY_W-1:0] duty,
  input  logic              up,
  output logic [DUTY_W-1:0] nxt
);
  // A step larger than the peak behaves exactly like a step equal to it.
  localparam int              STEP_C = (STEP > DUTY_MAX) ? DUTY_MAX : STEP;
  localparam logic [DUTY_W:0] STEP_X = (DUTY_W+1)'(STEP_C);
  localparam logic [DUTY_W:0] MAX_X  = (DUTY_W+1)'(DUTY_MAX);
  localparam logic [DUTY_W-1:0] STEP_N = DUTY_W'(STEP_C);
  localparam logic [DUTY_W-1:0] MAX_V  = DUTY_W'(DUTY_MAX);

  logic [DUTY_W:0] sum;

  // Sum is one bit wider than duty so the upward clamp never sees a wrap.
  always_comb begin
    sum = {1'b0, duty} + STEP_X;
    nxt = '0;
    if (up) begin
      nxt = (sum >= MAX_X) ? MAX_V : sum[DUTY_W-1:0];
    end else begin
      nxt = (duty > STEP_N) ? (duty - STEP_N) : '0;
    end
  end
endmodule

// File: rtl/led_breath_ctrl.sv
// Breathing duty sequencer: ramp up, hold high, ramp down, hold low, repeat.
// One duty value is handed to the PWM generator per transfer.
module led_breath_ctrl
  import led_pkg::*;
#(
  parameter int DUTY_W    = DUTY_W_DEF,
  parameter int DUTY_MAX  = DUTY_MAX_DEF,
  parameter int STEP      = 1,
  parameter int PRESCALE  = 4,
  parameter int HOLD_HIGH = 2,
  parameter int HOLD_LOW  = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en,
  led_breath_ctrl_if.master         bus,
  output logic                      ramp_dir,
  output logic                      cycle_done,
  output state_t                    state_dbg
);
  localparam int PMAX_A = (PRESCALE > HOLD_HIGH) ? PRESCALE : HOLD_HIGH;
  localparam int PMAX   = (PMAX_A > HOLD_LOW) ? PMAX_A : HOLD_LOW;
  localparam int PW     = (PMAX < 1) ? 1 : $clog2(PMAX + 1);

  localparam logic [PW-1:0]     LAST_PRE = PW'(PRESCALE - 1);
  localparam logic [PW-1:0]     LAST_HH  = PW'(HOLD_HIGH - 1);
  localparam logic [PW-1:0]     LAST_HL  = PW'(HOLD_LOW - 1);
  localparam logic [DUTY_W-1:0] MAX_V    = DUTY_W'(DUTY_MAX);

  state_t            state;
  logic [PW-1:0]     pcnt;
  logic [DUTY_W-1:0] duty_q;
  logic              valid_q;
  logic [DUTY_W-1:0] step_nxt;
  logic              step_up;
  logic              xfer;

  assign xfer           = valid_q & bus.duty_ready;
  assign bus.duty       = duty_q;
  assign bus.duty_valid = valid_q;
  assign state_dbg      = state;

  // Rising phases step upward; HOLD_L leaves into UP at one step above zero.
  assign step_up = (state == UP) || (state == HOLD_L);

  led_sat_step #(
    .DUTY_W   (DUTY_W),
    .DUTY_MAX (DUTY_MAX),
    .STEP     (STEP)
  ) u_step (
    .duty (duty_q),
    .up   (step_up),
    .nxt  (step_nxt)
  );

  // Phase sequencing; every state change and level load happens on a transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      pcnt       <= '0;
      duty_q     <= '0;
      valid_q    <= 1'b0;
      ramp_dir   <= 1'b0;
      cycle_done <= 1'b0;
    end else begin
      cycle_done <= 1'b0;
      if (state == IDLE) begin
        if (en) begin
          state    <= UP;
          pcnt     <= '0;
          duty_q   <= '0;
          valid_q  <= 1'b1;
          ramp_dir <= 1'b1;
        end
      end else if (xfer) begin
        if (!en) begin
          // Disable takes effect only at a transfer so valid never drops early.
          state    <= IDLE;
          pcnt     <= '0;
          duty_q   <= '0;
          valid_q  <= 1'b0;
          ramp_dir <= 1'b0;
        end else begin
          case (state)
            UP: begin
              if (pcnt == LAST_PRE) begin
                pcnt   <= '0;
                duty_q <= step_nxt;
                if (step_nxt == MAX_V) state <= HOLD_H;
              end else begin
                pcnt <= pcnt + 1'b1;
              end
            end
            HOLD_H: begin
              if (pcnt == LAST_HH) begin
                state    <= DOWN;
                pcnt     <= '0;
                duty_q   <= step_nxt;
                ramp_dir <= 1'b0;
              end else begin
                pcnt <= pcnt + 1'b1;
              end
            end
            DOWN: begin
              if (pcnt == LAST_PRE) begin
                pcnt   <= '0;
                duty_q <= step_nxt;
                if (step_nxt == '0) state <= HOLD_L;
              end else begin
                pcnt <= pcnt + 1'b1;
              end
            end
            HOLD_L: begin
              if (pcnt == LAST_HL) begin
                state      <= UP;
                pcnt       <= '0;
                duty_q     <= step_nxt;
                ramp_dir   <= 1'b1;
                cycle_done <= 1'b1;
              end else begin
                pcnt <= pcnt + 1'b1;
              end
            end
            default: begin
              state <= IDLE;
            end
          endcase
        end
      end
    end
  end
endmodule

// File: tb/tb_led_breath_ctrl.sv
// Bench for led_breath_ctrl: default config, a coarse full-cycle config and a
// saturating-step config, each with its own reset/enable/ready.
module tb_led_breath_ctrl;
  import led_pkg::*;

  localparam int W = 10;  // {dut index[1:0], duty[7:0]}

  logic clk = 1'b0;
  logic [2:0] rst_n_v;
  logic [2:0] en_v;
  logic [2:0] ready_v;

  led_breath_ctrl_if #(.DUTY_W(8)) bus_d ();
  led_breath_ctrl_if #(.DUTY_W(8)) bus_f ();
  led_breath_ctrl_if #(.DUTY_W(8)) bus_s ();

  logic   rd_d, rd_f, rd_s;
  logic   cd_d, cd_f, cd_s;
  state_t st_d, st_f, st_s;

  assign bus_d.duty_ready = ready_v[0];
  assign bus_f.duty_ready = ready_v[1];
  assign bus_s.duty_ready = ready_v[2];

  led_breath_ctrl u_def (
    .clk(clk), .rst_n(rst_n_v[0]), .en(en_v[0]), .bus(bus_d),
    .ramp_dir(rd_d), .cycle_done(cd_d), .state_dbg(st_d)
  );

  led_breath_ctrl #(
    .DUTY_W(8), .DUTY_MAX(255), .STEP(64), .PRESCALE(1), .HOLD_HIGH(1), .HOLD_LOW(1)
  ) u_fast (
    .clk(clk), .rst_n(rst_n_v[1]), .en(en_v[1]), .bus(bus_f),
    .ramp_dir(rd_f), .cycle_done(cd_f), .state_dbg(st_f)
  );

  led_breath_ctrl #(
    .DUTY_W(8), .DUTY_MAX(255), .STEP(100), .PRESCALE(1), .HOLD_HIGH(1), .HOLD_LOW(1)
  ) u_sat (
    .clk(clk), .rst_n(rst_n_v[2]), .en(en_v[2]), .bus(bus_s),
    .ramp_dir(rd_s), .cycle_done(cd_s), .state_dbg(st_s)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic push(input int sel, input int lvl, input int n);
    logic [1:0] s;
    logic [7:0] l;
    s = sel[1:0];
    l = lvl[7:0];
    repeat (n) exp_q.push_back({s, l});
  endtask

  // ---------------- driver ----------------
  // Called #1 after a rising edge; each pulse is one transfer (DUT is offering).
  task automatic xfers(input int sel, input int n, input int gap);
    repeat (n) begin
      repeat (gap) begin
        ready_v[sel] = 1'b0;
        @(posedge clk); #1;
      end
      ready_v[sel] = 1'b1;
      @(posedge clk); #1;
    end
    ready_v[sel] = 1'b0;
  endtask

  // ---------------- monitor ----------------
  logic [7:0] duty_m[3];
  logic       valid_m[3];
  logic       cd_m[3];
  assign duty_m[0] = bus_d.duty;  assign valid_m[0] = bus_d.duty_valid;  assign cd_m[0] = cd_d;
  assign duty_m[1] = bus_f.duty;  assign valid_m[1] = bus_f.duty_valid;  assign cd_m[1] = cd_f;
  assign duty_m[2] = bus_s.duty;  assign valid_m[2] = bus_s.duty_valid;  assign cd_m[2] = cd_s;

  logic [7:0]   prev_duty[3];
  logic         prev_valid[3] = '{1'b0, 1'b0, 1'b0};
  logic         prev_ready[3] = '{1'b0, 1'b0, 1'b0};
  logic         prev_rst[3]   = '{1'b0, 1'b0, 1'b0};
  logic         done_exp[3]   = '{1'b0, 1'b0, 1'b0};
  int           xfer_cnt[3]   = '{0, 0, 0};
  int           done_idx[3]   = '{-1, 8, 6};  // transfer index of the final zero
  logic [W-1:0] mon_e;
  logic [1:0]   mon_i;

  // Sample on the falling edge: what is seen here is what the next rising edge takes.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      mon_i = i[1:0];
      if (rst_n_v[i] && prev_rst[i] && prev_valid[i] && !prev_ready[i]) begin
        check("hold_valid", 32'(valid_m[i]), 32'd1);
        check("hold_duty", 32'(duty_m[i]), 32'(prev_duty[i]));
      end
      check("cycle_done", 32'(cd_m[i]), 32'(done_exp[i]));
      done_exp[i] = 1'b0;
      if (valid_m[i] && ready_v[i]) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL xfer: dut %0d duty %0d transferred, expected no transfer", i, duty_m[i]);
        end else begin
          mon_e = exp_q.pop_front();
          check("xfer_duty", 32'({mon_i, duty_m[i]}), 32'(mon_e));
          if (xfer_cnt[i] == done_idx[i]) done_exp[i] = 1'b1;
          xfer_cnt[i]++;
        end
      end
      prev_duty[i]  = duty_m[i];
      prev_valid[i] = valid_m[i];
      prev_ready[i] = ready_v[i];
      prev_rst[i]   = rst_n_v[i];
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    rst_n_v = 3'b000;
    en_v    = 3'b000;
    ready_v = 3'b001;

    // Reset / idle on the default config, ready high but nothing offered.
    repeat (2) @(posedge clk);
    #1 rst_n_v[0] = 1'b1;
    repeat (20) begin
      @(negedge clk);
      check("idle_duty", 32'(bus_d.duty), 32'd0);
      check("idle_valid", 32'(bus_d.duty_valid), 32'd0);
    end
    check("idle_state", 32'(st_d), 32'(IDLE));
    check("idle_dir", 32'(rd_d), 32'd0);

    // Backpressure: ready pulsed one clock in ten through the rise and peak hold.
    @(posedge clk); #1;
    ready_v[0] = 1'b0;
    en_v[0]    = 1'b1;
    @(posedge clk); #1;
    check("start_state", 32'(st_d), 32'(UP));
    check("start_dir", 32'(rd_d), 32'd1);
    for (int l = 0; l < 255; l++) push(0, l, 4);
    push(0, 255, 2);
    xfers(0, 1022, 9);
    check("after_hold_state", 32'(st_d), 32'(DOWN));
    check("after_hold_dir", 32'(rd_d), 32'd0);

    // Descend to level 100, three transfers into it.
    for (int l = 254; l > 100; l--) push(0, l, 4);
    push(0, 100, 3);
    xfers(0, 616 + 3, 0);
    check("down_state", 32'(st_d), 32'(DOWN));
    check("down_duty", 32'(bus_d.duty), 32'd100);

    // Disable mid-ramp with ready held low: offer stays up until the transfer.
    en_v[0] = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
      check("dis_valid", 32'(bus_d.duty_valid), 32'd1);
      check("dis_duty", 32'(bus_d.duty), 32'd100);
    end
    push(0, 100, 1);
    xfers(0, 1, 0);
    repeat (3) begin
      @(negedge clk);
      check("dis_idle_valid", 32'(bus_d.duty_valid), 32'd0);
      check("dis_idle_duty", 32'(bus_d.duty), 32'd0);
      check("dis_idle_state", 32'(st_d), 32'(IDLE));
    end

    // Async reset inside HOLD_H, then restart from zero.
    @(posedge clk); #1;
    en_v[0] = 1'b1;
    @(posedge clk); #1;
    for (int l = 0; l < 255; l++) push(0, l, 4);
    push(0, 255, 1);
    xfers(0, 1021, 0);
    check("pre_rst_state", 32'(st_d), 32'(HOLD_H));
    check("pre_rst_duty", 32'(bus_d.duty), 32'd255);
    #2 rst_n_v[0] = 1'b0;
    #1;
    check("arst_valid", 32'(bus_d.duty_valid), 32'd0);
    check("arst_duty", 32'(bus_d.duty), 32'd0);
    check("arst_state", 32'(st_d), 32'(IDLE));
    @(posedge clk); #1;
    rst_n_v[0] = 1'b1;
    @(posedge clk); #1;
    push(0, 0, 4);
    push(0, 1, 4);
    xfers(0, 8, 0);
    rst_n_v[0] = 1'b0;
    en_v[0]    = 1'b0;

    // Coarse full cycle: STEP 64, single-transfer levels and holds.
    @(posedge clk); #1;
    rst_n_v[1] = 1'b1;
    en_v[1]    = 1'b1;
    @(posedge clk); #1;
    push(1, 0, 1);   push(1, 64, 1);  push(1, 128, 1); push(1, 192, 1);
    push(1, 255, 1); push(1, 191, 1); push(1, 127, 1); push(1, 63, 1);
    push(1, 0, 1);   push(1, 64, 1);  push(1, 128, 1); push(1, 192, 1);
    xfers(1, 12, 0);
    rst_n_v[1] = 1'b0;
    en_v[1]    = 1'b0;

    // Saturating step of 100 at both ends.
    @(posedge clk); #1;
    rst_n_v[2] = 1'b1;
    en_v[2]    = 1'b1;
    @(posedge clk); #1;
    push(2, 0, 1);   push(2, 100, 1); push(2, 200, 1); push(2, 255, 1);
    push(2, 155, 1); push(2, 55, 1);  push(2, 0, 1);   push(2, 100, 1);
    xfers(2, 8, 0);
    rst_n_v[2] = 1'b0;
    en_v[2]    = 1'b0;

    // ---------------- report ----------------
    repeat (2) @(posedge clk);
    #1;
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
